alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: single-issue ALU with a valid/ready request side and a valid/ready result side.
// Most ops finish in one cycle. With ALU_PIPE_MUL_EN defined, op 1010 runs an iterative
// shift-add multiplier for WIDTH cycles. Without the macro, op 1010 is an undefined op.
//
// Ports:
//   clk, rst_n            clock; asynchronous active-low reset
//   in_valid, in_ready    request handshake; a, b, op are captured on acceptance
//   a, b [WIDTH-1:0]      operands
//   op [3:0]              operation code
//   out_valid, out_ready  result handshake; result and flags hold while stalled
//   result [WIDTH-1:0]    registered result
//   zero, cout, ovf       registered flags
module alu_pipe #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned ShW = $clog2(WIDTH);

  localparam logic [3:0] OpAnd  = 4'b0000;
  localparam logic [3:0] OpOr   = 4'b0001;
  localparam logic [3:0] OpAdd  = 4'b0010;
  localparam logic [3:0] OpSll  = 4'b0011;
  localparam logic [3:0] OpSrl  = 4'b0100;
  localparam logic [3:0] OpSra  = 4'b0101;
  localparam logic [3:0] OpSub  = 4'b0110;
  localparam logic [3:0] OpSlt  = 4'b0111;
  localparam logic [3:0] OpSltu = 4'b1000;
  localparam logic [3:0] OpXor  = 4'b1001;
  localparam logic [3:0] OpNor  = 4'b1100;

`ifdef ALU_PIPE_MUL_EN
  localparam logic [3:0] OpMul = 4'b1010;
  localparam int unsigned CntW = ShW + 1;
  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;
`else
  typedef enum logic {StIdle, StDone} state_e;
`endif

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

`ifdef ALU_PIPE_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;   // multiplicand, shifted left each step
  logic [WIDTH-1:0] mplier_q, mplier_d; // multiplier, shifted right each step
  logic [WIDTH-1:0] acc_q, acc_d;       // partial product
  logic [CntW-1:0]  cnt_q, cnt_d;
`endif

  // Single-cycle datapath
  logic             is_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic [ShW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cout;
  logic             alu_ovf;

  always_comb begin
    is_sub   = (op == OpSub);
    b_op     = is_sub ? ~b : b;
    // One adder serves ADD and SUB; carry-out of SUB is the inverted borrow.
    sum      = {1'b0, a} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
    shamt    = b[ShW-1:0];
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (op)
      OpAnd:  alu_res = a & b;
      OpOr:   alu_res = a | b;
      OpXor:  alu_res = a ^ b;
      OpNor:  alu_res = ~(a | b);
      OpSll:  alu_res = a << shamt;
      OpSrl:  alu_res = a >> shamt;
      OpSra:  alu_res = $signed(a) >>> shamt;
      OpSlt:  alu_res = {{(WIDTH - 1){1'b0}}, ($signed(a) < $signed(b))};
      OpSltu: alu_res = {{(WIDTH - 1){1'b0}}, (a < b)};
      OpAdd, OpSub: begin
        alu_res  = sum[WIDTH-1:0];
        alu_cout = sum[WIDTH];
        alu_ovf  = (a[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      default: ;
    endcase
  end

  logic accept;

  always_comb begin
    in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
    out_valid = (state_q == StDone);
    accept    = in_valid && in_ready;

    state_d  = state_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
`ifdef ALU_PIPE_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
`endif

    case (state_q)
      StIdle: ;
      StDone: if (out_ready) state_d = StIdle;
`ifdef ALU_PIPE_MUL_EN
      StCalc: begin
        // WIDTH shift-add steps, then one cycle to publish the product.
        if (cnt_q == CntW'(WIDTH)) begin
          result_d = acc_q;
          cout_d   = 1'b0;
          ovf_d    = 1'b0;
          state_d  = StDone;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CntW'(1);
        end
      end
`endif
      default: state_d = StIdle;
    endcase

    // Acceptance overrides the DONE->IDLE return for back-to-back issue.
    if (accept) begin
`ifdef ALU_PIPE_MUL_EN
      if (op == OpMul) begin
        mcand_d  = a;
        mplier_d = b;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = StCalc;
      end else begin
        result_d = alu_res;
        cout_d   = alu_cout;
        ovf_d    = alu_ovf;
        state_d  = StDone;
      end
`else
      result_d = alu_res;
      cout_d   = alu_cout;
      ovf_d    = alu_ovf;
      state_d  = StDone;
`endif
    end

    zero_d = (result_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      zero_q   <= 1'b1;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
`ifdef ALU_PIPE_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;

endmodule
